pwm_multi: RTL and testbench

PWM_MULTI -- requirements
Module: pwm_multi

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_timebase.sv | 76 +++++++
 rtl/pwm_multi.sv | 97 +++++++++
 tb/tb_pwm_multi.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared mode and direction types for the multi-channel PWM
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } pwm_dir_t;

endpackage

// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - shared PWM counter with edge/center modes and period boundary detect
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int N = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          step,
    input  logic [N-1:0]  period,
    input  pwm_mode_t     mode,
    output logic [N-1:0]  count,
    output logic          boundary,
    output logic          period_done
);

    localparam logic [N-1:0] ONE = N'(1);

    pwm_dir_t     dir;
    pwm_dir_t     dir_next;
    logic [N-1:0] count_next;
    logic         wrap;

    // Next count/direction if a step is taken now; wrap marks the step that ends a period
    always_comb begin
        count_next = count;
        dir_next   = dir;
        wrap       = 1'b0;
        if (period == '0) begin
            count_next = '0;
            dir_next   = UP;
            wrap       = 1'b1;
        end else if (mode == PWM_EDGE) begin
            dir_next = UP;
            if (count >= period) begin
                count_next = '0;
                wrap       = 1'b1;
            end else begin
                count_next = count + ONE;
            end
        end else begin
            if (dir == UP && count < period) begin
                count_next = count + ONE;
            end else begin
                count_next = count - ONE;
                dir_next   = DOWN;
            end
            if (count_next == '0) begin
                wrap     = 1'b1;
                dir_next = UP;
            end
        end
    end

    assign boundary = ena & step & wrap;

    // Counter advances only on enabled steps; disabling parks it at 0 counting up
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count       <= '0;
            dir         <= UP;
            period_done <= 1'b0;
        end else begin
            period_done <= boundary;
            if (!ena) begin
                count <= '0;
                dir   <= UP;
            end else if (step) begin
                count <= count_next;
                dir   <= dir_next;
            end
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel PWM with double-buffered duty/period/mode
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int N  = 8,
    parameter int CH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic            step,
    input  logic            load,
    input  logic [CH*N-1:0] duty,
    input  logic [N-1:0]    period,
    input  logic            mode,
    input  logic [CH-1:0]   pol,
    output logic [CH-1:0]   out,
    output logic            period_done
);

    logic [CH*N-1:0] duty_sh;
    logic [CH*N-1:0] duty_act;
    logic [N-1:0]    period_sh;
    logic [N-1:0]    period_act;
    pwm_mode_t       mode_sh;
    pwm_mode_t       mode_act;
    logic            pending;
    logic            take;
    logic [N-1:0]    count;
    logic            boundary;
    logic [CH-1:0]   raw;
    logic [CH-1:0]   out_next;

    pwm_timebase #(.N(N)) u_timebase (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .step        (step),
        .period      (period_act),
        .mode        (mode_act),
        .count       (count),
        .boundary    (boundary),
        .period_done (period_done)
    );

    // While idle the active set tracks the shadow; while running it only swaps at a boundary
    assign take = pending & (~ena | boundary);

    // Shadow captures on load; active copies the previous shadow so a coincident load waits a period
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty_sh    <= '0;
            duty_act   <= '0;
            period_sh  <= '1;
            period_act <= '1;
            mode_sh    <= PWM_EDGE;
            mode_act   <= PWM_EDGE;
            pending    <= 1'b0;
        end else begin
            if (take) begin
                duty_act   <= duty_sh;
                period_act <= period_sh;
                mode_act   <= mode_sh;
            end
            if (load) begin
                duty_sh   <= duty;
                period_sh <= period;
                mode_sh   <= pwm_mode_t'(mode);
                pending   <= 1'b1;
            end else if (take) begin
                pending <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        assign raw[i] = count < duty_act[i*N +: N];
    end

    // Idle outputs sit at the polarity level; running outputs are the polarity-adjusted compare
    always_comb begin
        out_next = pol;
        if (ena) begin
            out_next = raw ^ pol;
        end
    end

    // Registered outputs so every channel changes on the same edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out <= '0;
        end else begin
            out <= out_next;
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// tb/tb_pwm_multi.sv - directed self-checking bench for pwm_multi
module tb_pwm_multi;

    localparam int   N      = 8;
    localparam int   CH     = 4;
    localparam logic EDGE   = 1'b0;
    localparam logic CENTER = 1'b1;

    logic            clk = 1'b0;
    logic            rst;
    logic            ena;
    logic            step;
    logic            load;
    logic [CH*N-1:0] duty;
    logic [N-1:0]    period;
    logic            mode;
    logic [CH-1:0]   pol;
    logic [CH-1:0]   out;
    logic            period_done;

    logic [CH*N-1:0] cur_duty;
    logic [4:0]      hist [0:1023];
    int              n_cmp = 0;
    int              n_bad = 0;

    pwm_multi #(.N(N), .CH(CH)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .step        (step),
        .load        (load),
        .duty        (duty),
        .period      (period),
        .mode        (mode),
        .pol         (pol),
        .out         (out),
        .period_done (period_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // bit 4 of each history entry is period_done, bits 3:0 are out
    function automatic int cnt_high(input int b, input int from, input int len);
        int c = 0;
        for (int k = 0; k < len; k++) c += int'(hist[from+k][b]);
        return c;
    endfunction

    function automatic logic [31:0] mask(input int b, input int from, input int len);
        logic [31:0] m = '0;
        for (int k = 0; k < len; k++) m[k] = hist[from+k][b];
        return m;
    endfunction

    function automatic int first_pd(input int len);
        for (int k = 0; k < len; k++) if (hist[k][4]) return k;
        return -1;
    endfunction

    task automatic configure(input logic [CH*N-1:0] d, input logic [N-1:0] p,
                             input logic m, input logic [CH-1:0] pl);
        ena      = 1'b0;
        step     = 1'b0;
        duty     = d;
        period   = p;
        mode     = m;
        pol      = pl;
        cur_duty = d;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
    endtask

    // sample i is taken after the i-th posedge of the run
    task automatic run(input int n, input int sdiv, input int off_at, input int on_at,
                       input int la0, input logic [7:0] ld0, input int la1, input logic [7:0] ld1);
        for (int i = 0; i < n; i++) begin
            ena  = !(i >= off_at && i < on_at);
            step = (i % sdiv) == 0;
            load = (i == la0) || (i == la1);
            duty = cur_duty;
            if (i == la0) duty[7:0] = ld0;
            if (i == la1) duty[7:0] = ld1;
            @(negedge clk);
            hist[i] = {period_done, out};
        end
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b0; ena = 1'b0; step = 1'b0; load = 1'b0;
        duty = '0; period = '0; mode = EDGE; pol = 4'hF; cur_duty = '0;

        // reset dominates clock edges even with pol high
        @(negedge clk); @(negedge clk);
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_pd", 32'(period_done), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_pol", 32'(out), 32'hF);

        // EDGE P=9 duty 3: 3 high of 10, period_done every 10
        configure(32'h0000_0003, 8'd9, EDGE, 4'h0);
        run(30, 1, -1, -1, -1, 8'd0, -1, 8'd0);
        for (int p = 0; p < 3; p++) begin
            chk($sformatf("edge_out_p%0d", p), mask(0, 10*p, 10), 32'h007);
            chk($sformatf("edge_pd_p%0d", p), mask(4, 10*p, 10), 32'h200);
        end
        chk("edge_ch1_idle", 32'(cnt_high(1, 0, 30)), 32'd0);

        // CENTER P=4 duty ch1=2: counts 0,1,2,3,4,3,2,1 -> high on counts 0,1,1
        configure(32'h0000_0200, 8'd4, CENTER, 4'h0);
        run(24, 1, -1, -1, -1, 8'd0, -1, 8'd0);
        for (int p = 0; p < 3; p++) begin
            chk($sformatf("ctr_out_p%0d", p), mask(1, 8*p, 8), 32'h83);
            chk($sformatf("ctr_pd_p%0d", p), mask(4, 8*p, 8), 32'h80);
        end

        // duty 0 / 255 with P=254 across 3 periods, both polarities
        configure(32'h0000_FF00, 8'd254, EDGE, 4'h0);
        run(765, 1, -1, -1, -1, 8'd0, -1, 8'd0);
        chk("d0_low", 32'(cnt_high(0, 0, 765)), 32'd0);
        chk("d255_high", 32'(cnt_high(1, 0, 765)), 32'd765);
        chk("p254_pd_cnt", 32'(cnt_high(4, 0, 765)), 32'd3);
        chk("p254_pd_first", 32'(first_pd(765)), 32'd254);
        configure(32'h0000_FF00, 8'd254, EDGE, 4'h3);
        run(765, 1, -1, -1, -1, 8'd0, -1, 8'd0);
        chk("d0_inv", 32'(cnt_high(0, 0, 765)), 32'd765);
        chk("d255_inv", 32'(cnt_high(1, 0, 765)), 32'd0);

        // load 7 mid-period, then load 5 on a boundary edge: widths 3,7,7,5
        configure(32'h0000_0003, 8'd9, EDGE, 4'h0);
        run(40, 1, -1, -1, 4, 8'd7, 19, 8'd5);
        chk("ld_p0", mask(0, 0, 10), 32'h007);
        chk("ld_p1", mask(0, 10, 10), 32'h07F);
        chk("ld_p2", mask(0, 20, 10), 32'h07F);
        chk("ld_p3", mask(0, 30, 10), 32'h01F);

        // step every 3rd clk, ena low for edges 5..9, pol on ch0
        configure(32'h0000_0003, 8'd9, EDGE, 4'h1);
        run(45, 3, 5, 10, -1, 8'd0, -1, 8'd0);
        chk("ena_run", 32'(hist[4][3:0]), 32'h0);
        chk("ena_off_first", 32'(hist[5][3:0]), 32'h1);
        chk("ena_off_last", 32'(hist[9][3:0]), 32'h1);
        chk("ena_restart_lo", 32'(hist[18][0]), 32'h0);
        chk("ena_restart_hi", 32'(hist[19][0]), 32'h1);
        chk("ena_pd_cnt", 32'(cnt_high(4, 0, 45)), 32'd1);
        chk("ena_pd_first", 32'(first_pd(45)), 32'd39);

        // P=0: every step a boundary, duty above P stays high, both modes
        configure(32'h0000_0003, 8'd0, EDGE, 4'h0);
        run(6, 1, -1, -1, -1, 8'd0, -1, 8'd0);
        chk("p0e_pd", 32'(cnt_high(4, 0, 6)), 32'd6);
        chk("p0e_out", 32'(cnt_high(0, 0, 6)), 32'd6);
        configure(32'h0000_0003, 8'd0, CENTER, 4'h0);
        run(6, 1, -1, -1, -1, 8'd0, -1, 8'd0);
        chk("p0c_pd", 32'(cnt_high(4, 0, 6)), 32'd6);
        chk("p0c_out", 32'(cnt_high(0, 0, 6)), 32'd6);

        // leave a load pending, then reset asynchronously between edges
        duty = 32'h0000_0007; period = 8'd9; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("pre_rst_pd", 32'(period_done), 32'h1);
        chk("pre_rst_out", 32'(out), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_out", 32'(out), 32'h0);
        chk("async_rst_pd", 32'(period_done), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // defaults after release: duty 0, P=255, pending load discarded
        run(260, 1, -1, -1, -1, 8'd0, -1, 8'd0);
        chk("dflt_out", 32'(cnt_high(0, 0, 260)), 32'd0);
        chk("dflt_pd_first", 32'(first_pd(260)), 32'd255);
        chk("dflt_pd_cnt", 32'(cnt_high(4, 0, 260)), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
